// File: rtl/ppu_oam_port.sv
// OAM port: OAMADDR/OAMDATA CPU access, render-time write corruption,
// burst DMA write channel and a registered render-side read port.
module ppu_oam_port #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 8,
    parameter int ATTR_MASK_EN = 1,
    parameter int RENDER_BUMP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              oamaddr_write_en,
    input  logic [ADDR_W-1:0] oamaddr_in,
    input  logic              oamdata_write_en,
    input  logic [DATA_W-1:0] oamdata_in,
    input  logic              oamdata_read_en,
    output logic [DATA_W-1:0] oamdata_out,
    output logic              oamdata_read_valid,
    output logic              oamdata_write_complete,
    output logic [ADDR_W-1:0] oamaddr_out,
    input  logic              rendering,
    input  logic              dma_start,
    input  logic              dma_valid,
    input  logic [DATA_W-1:0] dma_data,
    output logic              dma_ready,
    output logic              dma_busy,
    output logic              dma_done,
    input  logic [ADDR_W-1:0] ppu_rd_addr,
    output logic [DATA_W-1:0] ppu_rd_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_BUMP = ADDR_W'(RENDER_BUMP);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_DMA  = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] oamaddr;
    logic [ADDR_W-1:0] dma_count;
    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;

    // Attribute bytes (addr[1:0]==2) have unimplemented bits [4:2] that read as 0.
    function automatic logic [DATA_W-1:0] attr_mask(input logic [ADDR_W-1:0] a,
                                                    input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] m;
        m = d;
        if (ATTR_MASK_EN != 0 && DATA_W == 8 && a[1:0] == 2'd2) begin
            for (int unsigned b = 2; b <= 4; b++) begin
                if (b < DATA_W) m[b] = 1'b0;
            end
        end
        return m;
    endfunction

    always_comb begin
        mem_we    = 1'b0;
        mem_wdata = oamdata_in;
        if (state == ST_DMA) begin
            mem_we    = dma_valid;
            mem_wdata = dma_data;
        end else if (!dma_start && !oamaddr_write_en && oamdata_write_en && !rendering) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && mem_we) mem[oamaddr] <= attr_mask(oamaddr, mem_wdata);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                  <= ST_IDLE;
            oamaddr                <= '0;
            dma_count              <= '0;
            oamdata_out            <= '0;
            oamdata_read_valid     <= 1'b0;
            oamdata_write_complete <= 1'b0;
            dma_ready              <= 1'b0;
            dma_busy               <= 1'b0;
            dma_done               <= 1'b0;
            ppu_rd_data            <= '0;
        end else begin
            oamdata_read_valid     <= 1'b0;
            oamdata_write_complete <= 1'b0;
            dma_done               <= 1'b0;
            ppu_rd_data            <= mem[ppu_rd_addr];

            if (oamdata_read_en) begin
                oamdata_read_valid <= 1'b1;
                oamdata_out        <= mem[oamaddr];
            end

            case (state)
                ST_IDLE: begin
                    if (dma_start) begin
                        state     <= ST_DMA;
                        dma_count <= '0;
                        dma_ready <= 1'b1;
                        dma_busy  <= 1'b1;
                    end else if (oamaddr_write_en) begin
                        oamaddr <= oamaddr_in;
                    end else if (oamdata_write_en) begin
                        oamdata_write_complete <= 1'b1;
                        oamaddr <= rendering ? oamaddr + ADDR_BUMP : oamaddr + ADDR_ONE;
                    end
                end
                ST_DMA: begin
                    if (dma_valid) begin
                        oamaddr   <= oamaddr + ADDR_ONE;
                        dma_count <= dma_count + ADDR_ONE;
                        if (dma_count == '1) begin
                            state     <= ST_IDLE;
                            dma_done  <= 1'b1;
                            dma_ready <= 1'b0;
                            dma_busy  <= 1'b0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign oamaddr_out = oamaddr;

endmodule
